// File: rtl/d_flip_flop_pkg.sv
// ---------------------------------------------------------------------------
// d_flip_flop_pkg
//
// Purpose:
//    Shared constants for the D-type storage register and for the 16-bit
//    Galois LFSR datapath that is built from it. The LFSR integration picks
//    up its register width and seed from here so the two stay in step.
//
// Contents:
//    DFF_DEFAULT_WIDTH      default number of stored bits (single-bit flop)
//    DFF_DEFAULT_RESET_VAL  default reset value (all zeros)
//    LFSR_WIDTH             register width used by the 16-bit LFSR
//    LFSR_SEED              reset value used by the 16-bit LFSR (non-zero, so
//                           the LFSR never starts in its lock-up state)
// ---------------------------------------------------------------------------
package d_flip_flop_pkg;

   localparam int unsigned DFF_DEFAULT_WIDTH     = 1;
   localparam int unsigned DFF_DEFAULT_RESET_VAL = 0;

   localparam int unsigned LFSR_WIDTH = 16;
   localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop_if.sv
// ---------------------------------------------------------------------------
// d_flip_flop_if
//
// Purpose:
//    Bundles the data path of one D-type register (data in, registered data
//    out) so a producer and the register can be wired with a single handle.
//    Clock and reset are not part of the bundle; they stay plain ports.
//
// Signals:
//    d   [WIDTH-1:0]  data presented to the register
//    q   [WIDTH-1:0]  registered output
//
// Modports:
//    master  drives d, observes q (the producer / consumer side)
//    slave   observes d, drives q (the register side)
// ---------------------------------------------------------------------------
interface d_flip_flop_if
   import d_flip_flop_pkg::*;
#(
   parameter int unsigned WIDTH = DFF_DEFAULT_WIDTH
);

   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;

   modport master (
      output d,
      input  q
   );

   modport slave (
      input  d,
      output q
   );

endinterface : d_flip_flop_if

// File: rtl/d_flip_flop.sv
// ---------------------------------------------------------------------------
// d_flip_flop
//
// Purpose:
//    Positive-edge D-type storage register with synchronous, active-high
//    reset. Default build is a single-bit flop; WIDTH > 1 gives a vector
//    register whose bits behave identically and independently. This is the
//    state-holding cell of the 16-bit Galois LFSR datapath and is also used
//    standalone as a pipeline / bit-storage element.
//
// Parameters:
//    WIDTH      number of stored bits (>= 1)
//    RESET_VAL  value loaded into Q on a reset edge, WIDTH bits wide
//
// Ports:
//    CLK  in   1      clock; all state changes happen on its rising edge
//    RST  in   1      synchronous active-high reset, sampled on rising CLK
//    D    in   WIDTH  data input, sampled on rising CLK
//    Q    out  WIDTH  registered output (no combinational path from inputs)
//
// Notes:
//    No power-up value is modelled: Q is undefined until the first rising
//    edge, and a reset edge is what gives it a known value. Reset wins over
//    D when both are presented at the same edge.
// ---------------------------------------------------------------------------
module d_flip_flop
   import d_flip_flop_pkg::*;
#(
   parameter int unsigned      WIDTH     = DFF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_DEFAULT_RESET_VAL)
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;

   // Next value is simply the data input; the reset choice is made inside
   // the clocked block so that reset stays strictly edge-sampled.
   always_comb begin
      q_d = D;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// ---------------------------------------------------------------------------
// tb_d_flip_flop
//
// Directed bench for d_flip_flop. Two builds run side by side on one clock:
//    dut_bit : WIDTH = 1,  RESET_VAL = 0
//    dut_vec : WIDTH = 16, RESET_VAL = 16'hACE1
// Inputs are changed away from rising edges; outputs are sampled 1 time unit
// after an edge or well inside a clock phase.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_d_flip_flop;
   import d_flip_flop_pkg::*;

   logic clk;
   logic rst_bit;
   logic rst_vec;

   int vec_cnt = 0;
   int err_cnt = 0;

   d_flip_flop_if #(.WIDTH(1))          bus_bit ();
   d_flip_flop_if #(.WIDTH(LFSR_WIDTH)) bus_vec ();

   d_flip_flop #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
   ) dut_bit (
      .CLK (clk),
      .RST (rst_bit),
      .D   (bus_bit.d),
      .Q   (bus_bit.q)
   );

   d_flip_flop #(
      .WIDTH     (LFSR_WIDTH),
      .RESET_VAL (16'hACE1)
   ) dut_vec (
      .CLK (clk),
      .RST (rst_vec),
      .D   (bus_vec.d),
      .Q   (bus_vec.q)
   );

   // Clock held low for a while so the first checks happen with no edge.
   initial begin
      clk = 1'b0;
      #20;
      forever #5 clk = ~clk;
   end

   // Absolute time bound: the run can never hang.
   initial begin
      #50000;
      $display("FAIL timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: %h (t=%0t)", tag, obs, $time);
      end
   endtask

   logic [15:0] pat [4];

   initial begin
      pat[0] = 16'hA5A5;
      pat[1] = 16'h0001;
      pat[2] = 16'h8000;
      pat[3] = 16'hFFFF;

      // Reset raised with CLK low, no edge yet: Q still undefined.
      rst_bit   = 1'b1;
      bus_bit.d = 1'b0;
      rst_vec   = 1'b1;
      bus_vec.d = 16'h0000;
      #5;

      // First rising edge with reset defines Q.
      @(posedge clk); #1;
      chk("bit_reset_edge", {15'd0, bus_bit.q}, 16'h0000);
      chk("vec_reset_edge", bus_vec.q, 16'hACE1);

      // Capture 1 (inputs changed while CLK high, after the edge).
      rst_bit   = 1'b0;
      bus_bit.d = 1'b1;
      @(posedge clk); #1;
      chk("bit_capture_1", {15'd0, bus_bit.q}, 16'h0001);

      // Reset raised while CLK high, no edge: Q holds.
      rst_bit = 1'b1;
      #2;
      chk("bit_rst_hi_no_edge_1", {15'd0, bus_bit.q}, 16'h0001);

      // Falling edge with RST=0, D=1, then RST=1 with CLK low: Q holds.
      rst_bit   = 1'b0;
      bus_bit.d = 1'b1;
      @(negedge clk); #1;
      chk("bit_falling_edge", {15'd0, bus_bit.q}, 16'h0001);
      rst_bit = 1'b1;
      #2;
      chk("bit_rst_lo_no_edge", {15'd0, bus_bit.q}, 16'h0001);

      // Capture 0.
      rst_bit   = 1'b0;
      bus_bit.d = 1'b0;
      @(posedge clk); #1;
      chk("bit_capture_0", {15'd0, bus_bit.q}, 16'h0000);
      rst_bit = 1'b1;
      #2;
      chk("bit_rst_hi_no_edge_0", {15'd0, bus_bit.q}, 16'h0000);

      // Reset priority: get Q=1, then reset with D=1, then release.
      rst_bit   = 1'b0;
      bus_bit.d = 1'b1;
      @(posedge clk); #1;
      chk("bit_prio_setup", {15'd0, bus_bit.q}, 16'h0001);
      rst_bit   = 1'b1;
      bus_bit.d = 1'b1;
      @(posedge clk); #1;
      chk("bit_prio_reset", {15'd0, bus_bit.q}, 16'h0000);
      rst_bit = 1'b0;
      @(posedge clk); #1;
      chk("bit_prio_release", {15'd0, bus_bit.q}, 16'h0001);

      // Vector build has been held in reset all along.
      chk("vec_held_reset", bus_vec.q, 16'hACE1);

      // Vector capture, then mid-cycle change of D.
      rst_vec   = 1'b0;
      bus_vec.d = 16'h1234;
      @(posedge clk); #1;
      chk("vec_capture", bus_vec.q, 16'h1234);
      bus_vec.d = 16'h5678;
      #2;
      chk("vec_mid_cycle_hi", bus_vec.q, 16'h1234);
      @(negedge clk); #1;
      chk("vec_mid_cycle_lo", bus_vec.q, 16'h1234);
      @(posedge clk); #1;
      chk("vec_next_edge", bus_vec.q, 16'h5678);

      // Per-bit independence across a few patterns.
      for (int i = 0; i < 4; i++) begin
         bus_vec.d = pat[i];
         @(posedge clk); #1;
         chk($sformatf("vec_pattern_%0d", i), bus_vec.q, pat[i]);
      end

      // Vector reset priority over D.
      rst_vec   = 1'b1;
      bus_vec.d = 16'h0F0F;
      @(posedge clk); #1;
      chk("vec_prio_reset", bus_vec.q, 16'hACE1);
      rst_vec = 1'b0;
      @(posedge clk); #1;
      chk("vec_prio_release", bus_vec.q, 16'h0F0F);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule : tb_d_flip_flop
